// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the cacheline-memory arbiter and its winner picker.
package mem_arb_pkg;
    typedef enum logic {IDLE, BUSY} arb_state_e;
    typedef enum logic {PRIO_RR, PRIO_FIXED} arb_prio_e;

    function automatic int line_w(input int s_off);
        return (2 ** s_off) * 8;
    endfunction
endpackage

// File: rtl/rr_picker.sv
// Combinational winner select: round-robin starting after rr_ptr, or lowest index in fixed mode.
module rr_picker #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  rr_ptr,
    input  logic              fixed_mode,
    output logic [NUM_CH-1:0] winner,
    output logic [IDX_W-1:0]  winner_idx,
    output logic              valid
);
    always_comb begin
        winner_idx = '0;
        valid      = 1'b0;
        if (fixed_mode) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (req[i]) begin
                    valid      = 1'b1;
                    winner_idx = IDX_W'(i);
                end
            end
        end else begin
            // Walk the offsets backwards so the closest set bit after rr_ptr is the last write.
            for (int k = NUM_CH; k >= 1; k--) begin
                int j;
                j = (int'(rr_ptr) + k) % NUM_CH;
                if (req[j]) begin
                    valid      = 1'b1;
                    winner_idx = IDX_W'(j);
                end
            end
        end
        winner = valid ? (NUM_CH'(1) << winner_idx) : '0;
    end
endmodule

// File: rtl/mem_arbiter_rr.sv
// N-channel cacheline arbiter in front of the single cacheline_adaptor port; the downstream
// request is registered and a just-served channel is masked for its first IDLE cycle.
module mem_arbiter_rr
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int s_offset  = 5,
    parameter int ADDR_W    = 32,
    parameter int PRIO_MODE = 0,
    localparam int LINE_W   = line_w(s_offset)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_CH-1:0]              ch_read_i,
    input  logic [NUM_CH-1:0]              ch_write_i,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_address_i,
    input  logic [NUM_CH-1:0][LINE_W-1:0]  ch_line_i,
    output logic [LINE_W-1:0]              ch_line_o,
    output logic [NUM_CH-1:0]              ch_resp_o,
    output logic                           pmem_read_o,
    output logic                           pmem_write_o,
    output logic [ADDR_W-1:0]              pmem_address_o,
    output logic [LINE_W-1:0]              pmem_line_o,
    input  logic [LINE_W-1:0]              pmem_line_i,
    input  logic                           pmem_resp_i,
    output logic [NUM_CH-1:0]              grant_o
);
    localparam int   IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic FIXED = (PRIO_MODE == int'(PRIO_FIXED));

    arb_state_e        state;
    logic [NUM_CH-1:0] grant, mask, req, win;
    logic [IDX_W-1:0]  rr_ptr, grant_idx, win_idx;
    logic              win_vld;

    assign req = (ch_read_i | ch_write_i) & ~mask;

    rr_picker #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_picker (
        .req        (req),
        .rr_ptr     (rr_ptr),
        .fixed_mode (FIXED),
        .winner     (win),
        .winner_idx (win_idx),
        .valid      (win_vld)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            grant          <= '0;
            grant_idx      <= '0;
            rr_ptr         <= IDX_W'(NUM_CH - 1);
            mask           <= '0;
            pmem_read_o    <= 1'b0;
            pmem_write_o   <= 1'b0;
            pmem_address_o <= '0;
            pmem_line_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mask <= '0;
                    if (win_vld) begin
                        state          <= BUSY;
                        grant          <= win;
                        grant_idx      <= win_idx;
                        // Read+write together resolves to a write.
                        pmem_write_o   <= ch_write_i[win_idx];
                        pmem_read_o    <= ~ch_write_i[win_idx];
                        pmem_address_o <= ch_address_i[win_idx];
                        pmem_line_o    <= ch_line_i[win_idx];
                    end
                end
                BUSY: begin
                    if (pmem_resp_i) begin
                        state        <= IDLE;
                        pmem_read_o  <= 1'b0;
                        pmem_write_o <= 1'b0;
                        grant        <= '0;
                        rr_ptr       <= grant_idx;
                        mask         <= grant;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign grant_o   = grant;
    assign ch_resp_o = (state == BUSY && pmem_resp_i) ? grant : '0;
    assign ch_line_o = pmem_line_i;

    a_rw_conflict: assert property (@(posedge clk) disable iff (!reset_n)
        (req & ch_read_i & ch_write_i) == '0);
    a_resp_idle: assert property (@(posedge clk) disable iff (!reset_n)
        !(state == IDLE && pmem_resp_i));
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench: 2-channel RR arbiter driven by hand, plus 4-channel RR and fixed-priority
// instances with an auto-responding adaptor to observe grant rotation.
module tb_mem_arbiter_rr;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]              ch_read = '0, ch_write = '0;
    logic [1:0][31:0]        ch_addr = '0;
    logic [1:0][255:0]       ch_line = '0;
    logic [255:0]            ch_line_out, pmem_line_out;
    logic [255:0]            pmem_line_in = '0;
    logic [1:0]              ch_resp, grant;
    logic                    pmem_read, pmem_write;
    logic                    pmem_resp = 1'b0;
    logic [31:0]             pmem_addr;

    mem_arbiter_rr dut (
        .clk(clk), .reset_n(reset_n), .ch_read_i(ch_read), .ch_write_i(ch_write),
        .ch_address_i(ch_addr), .ch_line_i(ch_line), .ch_line_o(ch_line_out),
        .ch_resp_o(ch_resp), .pmem_read_o(pmem_read), .pmem_write_o(pmem_write),
        .pmem_address_o(pmem_addr), .pmem_line_o(pmem_line_out), .pmem_line_i(pmem_line_in),
        .pmem_resp_i(pmem_resp), .grant_o(grant)
    );

    // Two 4-channel instances (RR and fixed) sharing request stimulus.
    logic [3:0]        rd4 = '0;
    logic [3:0]        wr4 = '0;
    logic [3:0][31:0]  addr4 = '0;
    logic [3:0][31:0]  line4 = '0;
    logic [31:0]       lo_r, lo_f, pl_r, pl_f, pa_r, pa_f;
    logic [3:0]        resp_r, resp_f, gnt_r, gnt_f;
    logic              prd_r, pwr_r, prd_f, pwr_f;
    logic              presp_r = 1'b0, presp_f = 1'b0;

    mem_arbiter_rr #(.NUM_CH(4), .s_offset(2), .PRIO_MODE(0)) dut4 (
        .clk(clk), .reset_n(reset_n), .ch_read_i(rd4), .ch_write_i(wr4),
        .ch_address_i(addr4), .ch_line_i(line4), .ch_line_o(lo_r), .ch_resp_o(resp_r),
        .pmem_read_o(prd_r), .pmem_write_o(pwr_r), .pmem_address_o(pa_r),
        .pmem_line_o(pl_r), .pmem_line_i(32'h0), .pmem_resp_i(presp_r), .grant_o(gnt_r)
    );
    mem_arbiter_rr #(.NUM_CH(4), .s_offset(2), .PRIO_MODE(1)) dut4f (
        .clk(clk), .reset_n(reset_n), .ch_read_i(rd4), .ch_write_i(wr4),
        .ch_address_i(addr4), .ch_line_i(line4), .ch_line_o(lo_f), .ch_resp_o(resp_f),
        .pmem_read_o(prd_f), .pmem_write_o(pwr_f), .pmem_address_o(pa_f),
        .pmem_line_o(pl_f), .pmem_line_i(32'h0), .pmem_resp_i(presp_f), .grant_o(gnt_f)
    );

    // Adaptor stand-in: answers in the first cycle an op is visible.
    initial forever begin
        @(posedge clk); #1;
        presp_r = prd_r | pwr_r;
        presp_f = prd_f | pwr_f;
    end

    int seq_r[$], seq_f[$];
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (resp_r[i]) seq_r.push_back(i);
            if (resp_f[i]) seq_f.push_back(i);
        end
    end

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    localparam logic [255:0] L_A5 = {32{8'hA5}};
    localparam logic [255:0] L_5A = {32{8'h5A}};

    initial begin
        tick(); tick();
        chk("rst_read",  256'(pmem_read), 256'(0));
        chk("rst_write", 256'(pmem_write), 256'(0));
        chk("rst_grant", 256'(grant), 256'(0));
        chk("rst_resp",  256'(ch_resp), 256'(0));
        chk("rst_addr",  256'(pmem_addr), 256'(0));
        reset_n = 1'b1;
        tick();

        // Single read on ch0, adaptor answers after 5 cycles.
        ch_addr[0] = 32'h0000_1000; ch_read = 2'b01; #1;
        chk("rd_not_yet", 256'(pmem_read), 256'(0));
        tick();
        chk("rd_op",    256'(pmem_read), 256'(1));
        chk("rd_wr_lo", 256'(pmem_write), 256'(0));
        chk("rd_addr",  256'(pmem_addr), 256'(32'h1000));
        chk("rd_grant", 256'(grant), 256'(2'b01));
        repeat (4) tick();
        chk("rd_hold", 256'(pmem_read), 256'(1));
        pmem_line_in = L_A5; pmem_resp = 1'b1; #1;
        chk("rd_resp", 256'(ch_resp), 256'(2'b01));
        chk("rd_line", ch_line_out, L_A5);
        tick();
        pmem_resp = 1'b0; ch_read = 2'b00; #1;
        chk("rd_resp_1cyc", 256'(ch_resp), 256'(0));
        chk("rd_done",      256'(pmem_read), 256'(0));
        chk("rd_gnt_clr",   256'(grant), 256'(0));
        tick();

        // Reset mid-BUSY drops the request asynchronously.
        ch_addr[0] = 32'h0000_2000; ch_read = 2'b01;
        tick();
        chk("mid_busy", 256'(pmem_read), 256'(1));
        reset_n = 1'b0; ch_read = 2'b00; #1;
        chk("arst_read",  256'(pmem_read), 256'(0));
        chk("arst_grant", 256'(grant), 256'(0));
        chk("arst_addr",  256'(pmem_addr), 256'(0));
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_idle", 256'(grant), 256'(0));

        // ch0 read and ch1 write together from reset pointer: ch0 first.
        ch_addr[0] = 32'h0000_3000; ch_addr[1] = 32'h0000_4000; ch_line[1] = L_5A;
        ch_read = 2'b01; ch_write = 2'b10;
        tick();
        chk("both_g0",    256'(grant), 256'(2'b01));
        chk("both_rd",    256'(pmem_read), 256'(1));
        chk("both_wr_lo", 256'(pmem_write), 256'(0));
        chk("both_addr0", 256'(pmem_addr), 256'(32'h3000));
        ch_addr[0] = 32'hDEAD_0000;
        tick();
        chk("addr_stable", 256'(pmem_addr), 256'(32'h3000));
        pmem_resp = 1'b1; #1;
        chk("both_resp0", 256'(ch_resp), 256'(2'b01));
        tick();
        pmem_resp = 1'b0; ch_read = 2'b00; #1;
        chk("gap_rd", 256'(pmem_read), 256'(0));
        chk("gap_wr", 256'(pmem_write), 256'(0));
        tick();
        chk("both_g1",    256'(grant), 256'(2'b10));
        chk("both_wr",    256'(pmem_write), 256'(1));
        chk("both_rd_lo", 256'(pmem_read), 256'(0));
        chk("both_addr1", 256'(pmem_addr), 256'(32'h4000));
        chk("both_wdata", pmem_line_out, L_5A);
        tick();
        pmem_resp = 1'b1; #1;
        chk("both_resp1", 256'(ch_resp), 256'(2'b10));
        tick();

        // ch1 keeps requesting past its resp: masked for one cycle, then a new grant.
        pmem_resp = 1'b0; ch_write = 2'b00; ch_read = 2'b10; #1;
        chk("stale_g0", 256'(grant), 256'(0));
        tick();
        chk("stale_masked", 256'(grant), 256'(0));
        tick();
        chk("stale_regrant", 256'(grant), 256'(2'b10));
        chk("stale_rd",      256'(pmem_read), 256'(1));
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; ch_read = 2'b00;
        tick();

        // 4-channel rotation and fixed-priority starvation.
        rd4 = 4'hF;
        for (int c = 0; c < 100 && (seq_r.size() < 6 || seq_f.size() < 4); c++) tick();
        rd4 = 4'h0;
        chk("rr4_count",  256'(seq_r.size() >= 6), 256'(1));
        chk("fix4_count", 256'(seq_f.size() >= 4), 256'(1));
        if (seq_r.size() >= 6) begin
            int exp_r[6] = '{0, 1, 2, 3, 0, 1};
            for (int i = 0; i < 6; i++) chk($sformatf("rr4_seq%0d", i), 256'(seq_r[i]), 256'(exp_r[i]));
        end
        if (seq_f.size() >= 4) begin
            int exp_f[4] = '{0, 1, 0, 1};
            for (int i = 0; i < 4; i++) chk($sformatf("fix4_seq%0d", i), 256'(seq_f[i]), 256'(exp_f[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
